pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Parametrised program-counter sequencer for the MIPS datapath. It holds the fetch address and advances it by a fixed increment each cycle. It also arbitrates stall, branch, jump, call and return redirects, with an optional hardware return-address stack. It sits at the head of the fetch stage, and its output drives instruction-memory addressing.

## Interface

Parameters:
- AW, 32: address width in bits
- INC, 4: sequential increment (bytes per instruction)
- RESET_VEC, 0: PCO value held during and just after reset
- RAS_DEPTH, 4: return-address stack entries, power of two ≥2 (used only when PC_RAS_EN is defined)

Ports:
- CLK  input  1  clock; all state changes on rising edge
- RST  input  1  reset, asynchronous, active-high
- STALL  input  1  hold PCO and all internal state
- BR_TAKEN  input  1  conditional branch resolved taken
- BR_TARGET  input  AW  branch destination
- JMP  input  1  unconditional jump (J / JAL / JR)
- JMP_TARGET  input  AW  jump destination; also the fallback return target
- CALL  input  1  qualifies JMP as a call (JAL); push PCO+INC
- RET  input  1  return (JR $ra); redirect to stack top or JMP_TARGET
- PCO  output  AW  registered current fetch address
- PC_NEXT  output  AW  combinational value PCO takes at the next non-stalled edge
- PC_VALID  output  1  PCO holds a fetchable address
- RAS_EMPTY  output  1  stack holds no entries (constant 1 when the feature is out)
- RAS_OVF  output  1  sticky: a push occurred while the stack was full

## Operation

- States:
  - RESET: RST high.
  - BOOT: first edge after RST falls.
  - RUN.
- RESET→BOOT on RST deassertion. BOOT→RUN on the next edge, regardless of STALL.
- In BOOT, PCO stays RESET_VEC and PC_VALID rises to 1. The first instruction fetched is therefore RESET_VEC.
- In RUN, next-PC selection uses this priority:
  - STALL: hold.
  - RET: return target.
  - JMP: JMP_TARGET.
  - BR_TAKEN: BR_TARGET.
  - Otherwise: PCO+INC.
- Address arithmetic is modulo 2^AW. PCO = 2^AW−INC sequences to 0; no flag is raised.
- Targets are used unmodified; no alignment masking.
- CALL without JMP is ignored. RET together with JMP: RET wins. RET together with CALL: the pop happens first, then the push, so the stack depth is unchanged and the top is replaced.
- Return-address stack (feature in):
  - Push on JMP&CALL, writing PCO+INC.
  - RET with a non-empty stack redirects to the top entry and pops it.
  - RET with an empty stack redirects to JMP_TARGET; the stack is unchanged.
  - Push when full overwrites the oldest entry (circular) and sets RAS_OVF. The count stays at RAS_DEPTH.
- STALL freezes PCO, the stack pointer, the count and the stack contents. PC_NEXT shows the held PCO while STALL is high.

## Timing

- Reset values: PCO=RESET_VEC, PC_VALID=0, RAS_EMPTY=1, RAS_OVF=0, stack count=0. Stack entries are undefined.
- RST asserted mid-operation takes effect immediately and asynchronously, including mid-stall or mid-redirect.
- Redirect latency is one edge: inputs sampled at edge N appear on PCO after edge N.
- PC_NEXT is purely combinational from PCO, the controls and the stack top. There is no register between PC_NEXT and PCO.
- RAS_EMPTY and RAS_OVF are registered and update on the same edge as the push or pop.

## Configuration

- Macro: PC_RAS_EN.
- Defined:
  - The stack is instantiated.
  - RET uses the stack top when the stack is non-empty.
  - RAS_EMPTY and RAS_OVF are live.
- Undefined:
  - No stack storage.
  - RET behaves exactly as JMP to JMP_TARGET.
  - CALL is ignored beyond its JMP.
  - RAS_EMPTY is tied to 1 and RAS_OVF to 0.
  - RAS_DEPTH is unused.

## Structure

- Shared package pc_pkg contains:
  - Next-PC select enum: SEL_HOLD, SEL_RET, SEL_JMP, SEL_BR, SEL_SEQ.
  - Sequencer state enum: ST_RESET, ST_BOOT, ST_RUN.
  - Default constants for AW, INC and RESET_VEC.
- One sub-module, pc_ras:
  - Circular LIFO with push, pop, top, empty, full and overflow outputs.
  - Parameters: AW and RAS_DEPTH.
  - Instantiated only under PC_RAS_EN.

## Test plan

- Reset/boot: hold RST 3 cycles, then release.
  - PCO=0 through the BOOT edge; PC_VALID=1 after the first edge.
  - PCO sequence after that: 0x4, 0x8, 0xC.
- Stall and priority:
  - STALL at PCO=0x10 for 2 cycles: PCO holds 0x10, then continues to 0x14.
  - BR_TAKEN(0x100) with JMP(0x200) in the same cycle: PCO=0x200.
- Wrap: AW=8, start at PCO=0xFC, no redirects. Next PCO=0x00 with no flag.
- Call/return:
  - JMP+CALL to 0x400 at PCO=0x20: PCO=0x400.
  - Later RET with JMP_TARGET=0xDEAD: PCO=0x24 and RAS_EMPTY=1.
- Overflow: RAS_DEPTH=4, 5 calls from PCs 0x0, 0x10, 0x20, 0x30, 0x40.
  - RAS_OVF=1 after the fifth call.
  - Four RETs yield 0x44, 0x34, 0x24, 0x14.
  - A fifth RET falls back to JMP_TARGET.
- Async reset mid-call: assert RST between clock edges while CALL and JMP are active.
  - PCO=0x0, RAS_EMPTY=1 and RAS_OVF=0 immediately, before the next edge.
  - With PC_RAS_EN undefined, rerun the call/return case: RET goes to JMP_TARGET=0xDEAD.

Source files
------------

// File: rtl/pc_pkg.sv
// pc_pkg: shared types and default constants for the program-counter sequencer.
//   pc_sel_e   : next-PC source select (hold / return / jump / branch / sequential)
//   pc_state_e : sequencer life-cycle state (reset / boot / run)
//   PC_*_DEF   : default parameter values for address width, increment,
//                reset vector and return-address stack depth
package pc_pkg;

  localparam int          PC_AW_DEF        = 32;
  localparam int          PC_INC_DEF       = 4;
  localparam logic [31:0] PC_RESET_VEC_DEF = 32'h0000_0000;
  localparam int          PC_RAS_DEPTH_DEF = 4;

  typedef enum logic [2:0] {
    SEL_HOLD = 3'd0,
    SEL_RET  = 3'd1,
    SEL_JMP  = 3'd2,
    SEL_BR   = 3'd3,
    SEL_SEQ  = 3'd4
  } pc_sel_e;

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_BOOT  = 2'd1,
    ST_RUN   = 2'd2
  } pc_state_e;

endpackage

// File: rtl/pc_ras.sv
// pc_ras: circular return-address stack (LIFO) for the PC sequencer.
// A push onto a full stack overwrites the oldest entry and sets the sticky
// overflow flag; the entry count saturates at RAS_DEPTH. A simultaneous pop
// and push replaces the top entry in place (depth unchanged).
// Ports:
//   CLK, RST : clock, asynchronous active-high reset
//   push     : write din as the new top entry
//   pop      : remove the top entry (ignored while empty)
//   din      : address to push
//   top      : current top entry (undefined while empty)
//   empty    : registered, stack holds no entries
//   full     : registered, stack holds RAS_DEPTH entries
//   ovf      : registered sticky flag, a push happened while full
module pc_ras #(
  parameter int AW        = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          push,
  input  logic          pop,
  input  logic [AW-1:0] din,
  output logic [AW-1:0] top,
  output logic          empty,
  output logic          full,
  output logic          ovf
);

  localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(RAS_DEPTH);

  logic [AW-1:0] mem_r [RAS_DEPTH];
  // ptr_r addresses the next free slot; the top entry sits just below it.
  // With a power-of-two depth the pointer wraps naturally, which is what
  // makes an overflowing push land on the oldest entry.
  logic [PW-1:0] ptr_r, ptr_nxt_s, top_idx_s, wr_idx_s;
  logic [CW-1:0] cnt_r, cnt_nxt_s;
  logic          empty_r, full_r, ovf_r;
  logic          wr_en_s, do_pop_s, ovf_set_s;

  assign top_idx_s = ptr_r - PW'(1);
  assign do_pop_s  = pop & ~empty_r;
  assign top       = mem_r[top_idx_s];
  assign empty     = empty_r;
  assign full      = full_r;
  assign ovf       = ovf_r;

  // Next pointer / count / write-slot selection for push, pop and pop+push
  always_comb begin
    ptr_nxt_s = ptr_r;
    cnt_nxt_s = cnt_r;
    wr_en_s   = 1'b0;
    wr_idx_s  = ptr_r;
    ovf_set_s = 1'b0;
    if (do_pop_s && push) begin
      // pop then push: overwrite the top in place
      wr_en_s  = 1'b1;
      wr_idx_s = top_idx_s;
    end else if (do_pop_s) begin
      ptr_nxt_s = top_idx_s;
      cnt_nxt_s = cnt_r - CW'(1);
    end else if (push) begin
      wr_en_s   = 1'b1;
      wr_idx_s  = ptr_r;
      ptr_nxt_s = ptr_r + PW'(1);
      if (full_r) begin
        cnt_nxt_s = cnt_r;
        ovf_set_s = 1'b1;
      end else begin
        cnt_nxt_s = cnt_r + CW'(1);
      end
    end else begin
      ptr_nxt_s = ptr_r;
    end
  end

  // Pointer, count and status flag registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ptr_r   <= PW'(0);
      cnt_r   <= CW'(0);
      empty_r <= 1'b1;
      full_r  <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      ptr_r   <= ptr_nxt_s;
      cnt_r   <= cnt_nxt_s;
      empty_r <= (cnt_nxt_s == CW'(0));
      full_r  <= (cnt_nxt_s == DEPTH_C);
      ovf_r   <= ovf_r | ovf_set_s;
    end
  end

  // Stack storage; contents are undefined after reset and need no reset
  always_ff @(posedge CLK) begin
    if (wr_en_s) begin
      mem_r[wr_idx_s] <= din;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter sequencer at the head of the fetch stage.
// Holds the fetch address, advances it by INC each cycle and arbitrates
// stall / return / jump / branch redirects (in that priority).
// Optional feature macro: PC_RAS_EN -- when defined a hardware return-address
// stack (pc_ras) serves RET; when undefined RET acts as a jump to JMP_TARGET,
// RAS_EMPTY is tied to 1 and RAS_OVF to 0.
// Ports:
//   CLK, RST    : clock, asynchronous active-high reset
//   STALL       : hold PCO and all internal state
//   BR_TAKEN    : branch taken, redirect to BR_TARGET
//   JMP         : unconditional jump to JMP_TARGET
//   CALL        : qualifies JMP as a call, pushes PCO+INC
//   RET         : return to stack top (or JMP_TARGET if stack empty)
//   PCO         : registered fetch address
//   PC_NEXT     : combinational value PCO takes at the next non-stalled edge
//   PC_VALID    : PCO holds a fetchable address
//   RAS_EMPTY   : return stack empty
//   RAS_OVF     : sticky return stack overflow
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int            AW        = PC_AW_DEF,
  parameter int            INC       = PC_INC_DEF,
  parameter logic [AW-1:0] RESET_VEC = AW'(PC_RESET_VEC_DEF),
  parameter int            RAS_DEPTH = PC_RAS_DEPTH_DEF
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          STALL,
  input  logic          BR_TAKEN,
  input  logic [AW-1:0] BR_TARGET,
  input  logic          JMP,
  input  logic [AW-1:0] JMP_TARGET,
  input  logic          CALL,
  input  logic          RET,
  output logic [AW-1:0] PCO,
  output logic [AW-1:0] PC_NEXT,
  output logic          PC_VALID,
  output logic          RAS_EMPTY,
  output logic          RAS_OVF
);

  pc_state_e     state_r, state_nxt_s;
  pc_sel_e       sel_s;
  logic [AW-1:0] pco_r, pc_seq_s, pc_next_s, ret_tgt_s;
  logic          valid_r, active_s;

  // The edge that leaves reset only boots: PCO must stay at RESET_VEC.
  assign active_s = (state_r != ST_RESET);
  // Wraps modulo 2^AW by construction.
  assign pc_seq_s = pco_r + AW'(INC);

`ifdef PC_RAS_EN
  logic          push_s, pop_s, ras_empty_s, ras_ovf_s, ras_full_unused_s;
  logic [AW-1:0] ras_top_s;

  assign push_s    = active_s & ~STALL & JMP & CALL;
  assign pop_s     = active_s & ~STALL & RET & ~ras_empty_s;
  assign ret_tgt_s = ras_empty_s ? JMP_TARGET : ras_top_s;

  pc_ras #(
    .AW        (AW),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .CLK   (CLK),
    .RST   (RST),
    .push  (push_s),
    .pop   (pop_s),
    .din   (pc_seq_s),
    .top   (ras_top_s),
    .empty (ras_empty_s),
    .full  (ras_full_unused_s),
    .ovf   (ras_ovf_s)
  );

  assign RAS_EMPTY = ras_empty_s;
  assign RAS_OVF   = ras_ovf_s;
`else
  localparam int ras_depth_unused = RAS_DEPTH;
  logic call_unused_s;

  assign call_unused_s = CALL;
  assign ret_tgt_s     = JMP_TARGET;
  assign RAS_EMPTY     = 1'b1;
  assign RAS_OVF       = 1'b0;
`endif

  // Next-state logic: reset -> boot -> run, independent of STALL
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_RESET: state_nxt_s = ST_BOOT;
      ST_BOOT:  state_nxt_s = ST_RUN;
      ST_RUN:   state_nxt_s = ST_RUN;
      default:  state_nxt_s = ST_RESET;
    endcase
  end

  // Next-PC source priority: hold, return, jump, branch, sequential
  always_comb begin
    sel_s = SEL_SEQ;
    if (!active_s) begin
      sel_s = SEL_HOLD;
    end else if (STALL) begin
      sel_s = SEL_HOLD;
    end else if (RET) begin
      sel_s = SEL_RET;
    end else if (JMP) begin
      sel_s = SEL_JMP;
    end else if (BR_TAKEN) begin
      sel_s = SEL_BR;
    end else begin
      sel_s = SEL_SEQ;
    end
  end

  // Next-PC multiplexer; targets are used unmodified
  always_comb begin
    pc_next_s = pco_r;
    case (sel_s)
      SEL_HOLD: pc_next_s = pco_r;
      SEL_RET:  pc_next_s = ret_tgt_s;
      SEL_JMP:  pc_next_s = JMP_TARGET;
      SEL_BR:   pc_next_s = BR_TARGET;
      SEL_SEQ:  pc_next_s = pc_seq_s;
      default:  pc_next_s = pco_r;
    endcase
  end

  // State, fetch address and valid flag registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r <= ST_RESET;
      pco_r   <= RESET_VEC;
      valid_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      pco_r   <= pc_next_s;
      valid_r <= 1'b1;
    end
  end

  assign PCO      = pco_r;
  assign PC_NEXT  = pc_next_s;
  assign PC_VALID = valid_r;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed self-checking bench for pc_sequencer.
// Expectations follow the PC_RAS_EN build setting of the compile.
module tb_pc_sequencer;

`ifdef PC_RAS_EN
  localparam bit RAS = 1'b1;
`else
  localparam bit RAS = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST;
  logic        STALL, BR_TAKEN, JMP, CALL, RET;
  logic [31:0] BR_TARGET, JMP_TARGET;
  logic [31:0] PCO, PC_NEXT;
  logic        PC_VALID, RAS_EMPTY, RAS_OVF;

  logic        stall8, br8, jmp8, call8, ret8;
  logic [7:0]  bt8, jt8;
  logic [7:0]  pco8, pcn8;
  logic        valid8, empty8, ovf8;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  pc_sequencer #(.AW(32), .INC(4), .RESET_VEC(32'h0), .RAS_DEPTH(4)) dut (
    .CLK(CLK), .RST(RST), .STALL(STALL), .BR_TAKEN(BR_TAKEN), .BR_TARGET(BR_TARGET),
    .JMP(JMP), .JMP_TARGET(JMP_TARGET), .CALL(CALL), .RET(RET),
    .PCO(PCO), .PC_NEXT(PC_NEXT), .PC_VALID(PC_VALID),
    .RAS_EMPTY(RAS_EMPTY), .RAS_OVF(RAS_OVF)
  );

  pc_sequencer #(.AW(8), .INC(4), .RESET_VEC(8'h0), .RAS_DEPTH(4)) dut8 (
    .CLK(CLK), .RST(RST), .STALL(stall8), .BR_TAKEN(br8), .BR_TARGET(bt8),
    .JMP(jmp8), .JMP_TARGET(jt8), .CALL(call8), .RET(ret8),
    .PCO(pco8), .PC_NEXT(pcn8), .PC_VALID(valid8),
    .RAS_EMPTY(empty8), .RAS_OVF(ovf8)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic idle();
    STALL = 1'b0; BR_TAKEN = 1'b0; JMP = 1'b0; CALL = 1'b0; RET = 1'b0;
  endtask

  initial begin
    RST = 1'b1;
    idle();
    BR_TARGET = 32'h0; JMP_TARGET = 32'h0;
    stall8 = 1'b0; br8 = 1'b0; jmp8 = 1'b0; call8 = 1'b0; ret8 = 1'b0;
    bt8 = 8'h0; jt8 = 8'h0;

    // reset held three cycles
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_pco",     PCO, 32'h0);
    chk("rst_pcnext",  PC_NEXT, 32'h0);
    chk("rst_valid",   32'(PC_VALID), 32'h0);
    chk("rst_empty",   32'(RAS_EMPTY), 32'h1);
    chk("rst_ovf",     32'(RAS_OVF), 32'h0);
    RST = 1'b0;

    // boot edge keeps RESET_VEC, then sequential fetch
    step();
    chk("boot_pco",    PCO, 32'h0);
    chk("boot_valid",  32'(PC_VALID), 32'h1);
    step(); chk("seq_4", PCO, 32'h4);
    step(); chk("seq_8", PCO, 32'h8);
    step(); chk("seq_c", PCO, 32'hC);
    step(); chk("seq_10", PCO, 32'h10);

    // two-cycle stall at 0x10
    STALL = 1'b1; #1;
    chk("stall_pcnext", PC_NEXT, 32'h10);
    step(); chk("stall_1", PCO, 32'h10);
    step(); chk("stall_2", PCO, 32'h10);
    STALL = 1'b0;
    step(); chk("stall_resume", PCO, 32'h14);

    // jump beats branch
    BR_TAKEN = 1'b1; BR_TARGET = 32'h100; JMP = 1'b1; JMP_TARGET = 32'h200; #1;
    chk("prio_pcnext", PC_NEXT, 32'h200);
    step(); chk("prio_jmp_over_br", PCO, 32'h200);
    JMP = 1'b0;
    step(); chk("br_only", PCO, 32'h100);
    idle();
    step(); chk("after_br", PCO, 32'h104);

    // 8-bit instance wrap-around from 0xFC
    jmp8 = 1'b1; jt8 = 8'hFC;
    step(); chk("w8_pco_fc", 32'(pco8), 32'hFC);
    jmp8 = 1'b0; #1;
    chk("w8_pcnext", 32'(pcn8), 32'h00);
    step(); chk("w8_wrap", 32'(pco8), 32'h00);
    chk("w8_ovf", 32'(ovf8), 32'h0);

    // call / return
    JMP = 1'b1; JMP_TARGET = 32'h20;
    step(); chk("goto_20", PCO, 32'h20);
    CALL = 1'b1; JMP_TARGET = 32'h400;
    step(); chk("call_400", PCO, 32'h400);
    chk("call_empty", 32'(RAS_EMPTY), RAS ? 32'h0 : 32'h1);
    idle();
    step(); chk("callee_seq", PCO, 32'h404);
    RET = 1'b1; JMP = 1'b1; JMP_TARGET = 32'hDEAD; #1;
    chk("ret_pcnext", PC_NEXT, RAS ? 32'h24 : 32'hDEAD);
    step(); chk("ret_pco", PCO, RAS ? 32'h24 : 32'hDEAD);
    chk("ret_empty", 32'(RAS_EMPTY), 32'h1);
    idle();

    // overflow: five calls from 0x0, 0x10, 0x20, 0x30, 0x40
    JMP = 1'b1; JMP_TARGET = 32'h0;
    step(); chk("goto_0", PCO, 32'h0);
    CALL = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      JMP_TARGET = 32'(i * 16);
      step();
      chk("ovf_call_pco", PCO, 32'(i * 16));
      if (i == 4) chk("ovf_before", 32'(RAS_OVF), 32'h0);
    end
    chk("ovf_after", 32'(RAS_OVF), RAS ? 32'h1 : 32'h0);
    CALL = 1'b0; RET = 1'b1; JMP_TARGET = 32'hBEEF;
    step(); chk("ret_44", PCO, RAS ? 32'h44 : 32'hBEEF);
    step(); chk("ret_34", PCO, RAS ? 32'h34 : 32'hBEEF);
    step(); chk("ret_24", PCO, RAS ? 32'h24 : 32'hBEEF);
    step(); chk("ret_14", PCO, RAS ? 32'h14 : 32'hBEEF);
    chk("ret4_empty", 32'(RAS_EMPTY), 32'h1);
    step(); chk("ret_fallback", PCO, 32'hBEEF);
    chk("ovf_sticky", 32'(RAS_OVF), RAS ? 32'h1 : 32'h0);
    idle();

    // asynchronous reset while a call is being presented
    JMP = 1'b1; CALL = 1'b1; JMP_TARGET = 32'h600;
    step(); chk("pre_rst_pco", PCO, 32'h600);
    chk("pre_rst_empty", 32'(RAS_EMPTY), RAS ? 32'h0 : 32'h1);
    #2 RST = 1'b1;
    #1;
    chk("arst_pco",   PCO, 32'h0);
    chk("arst_valid", 32'(PC_VALID), 32'h0);
    chk("arst_empty", 32'(RAS_EMPTY), 32'h1);
    chk("arst_ovf",   32'(RAS_OVF), 32'h0);
    @(negedge CLK);
    idle();
    RST = 1'b0;
    step(); chk("reboot_pco", PCO, 32'h0);
    step(); chk("reboot_seq", PCO, 32'h4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
